fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage at the front of the 5-stage pipeline. Owns the PC and drives the instruction-memory address.
- Registers the fetched instruction and its PC into the IF/ID boundary for the decoder.
- Next-PC sources: sequential, J/JAL (decoded in fetch), JR (target resolved downstream) and taken branches (resolved in EX).
- Branch policy is predict-not-taken; a taken branch flushes younger instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP, 32'h0000_0000, encoding used for injected bubbles

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
imemData  in  32  instruction word at imemAddr, combinational read
imemAddr  out  32  current PC, equal to pc register
stall  in  1  load-use hold from decode hazard logic
brTaken  in  1  EX-stage branch resolved taken, this cycle
brTarget  in  32  branch target, valid when brTaken
jrValid  in  1  JR register value available, this cycle
jrTarget  in  32  JR target, valid when jrValid
cmdOut  out  32  IF/ID instruction register
pcOut  out  32  PC of cmdOut (link value is pcOut+4)
cmdValid  out  1  cmdOut is a real instruction, not a bubble
flush  out  1  combinational copy of brTaken; tells IF/ID consumers to squash the instruction currently in decode
bubbleCount  out  16  count of injected bubbles, saturating

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, cmdOut=NOP, pcOut=0, cmdValid=0, bubbleCount=0, state=RUN.
  - When reset deasserts, the first fetch from RESET_PC is registered on the first clk edge.
- Latency: the instruction at PC p appears on cmdOut one edge after imemAddr=p, unless overridden below.
- Decode of imemData in fetch:
  - J is opcode[31:26]=000010; JAL is 000011.
  - JR is opcode 000000 with funct[5:0]=001000.
- Jump target: {pc+4[31:28], imemData[25:0], 2'b00}.
- pc+4 uses 32-bit arithmetic and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- States are RUN and WAIT_JR.
- Per-edge priority, highest first:
  1. brTaken (either state): pc<=brTarget; cmdOut<=NOP; cmdValid<=0; state<=RUN.
     - Overrides stall, jrValid and any jump in imemData.
     - A JR awaiting its target is abandoned.
  2. RUN and stall: pc, cmdOut, pcOut and cmdValid hold. No bubble is counted; decode re-presents its own instruction.
  3. WAIT_JR and jrValid: pc<=jrTarget; cmdOut<=NOP; cmdValid<=0; state<=RUN. stall is ignored in this case.
  4. WAIT_JR, no jrValid: pc holds; cmdOut<=NOP; cmdValid<=0.
  5. RUN, imemData is J/JAL: cmdOut<=imemData; pcOut<=pc; cmdValid<=1; pc<=jump target. This is a zero-bubble redirect.
  6. RUN, imemData is JR: cmdOut<=imemData; pcOut<=pc; cmdValid<=1; pc holds; state<=WAIT_JR.
  7. RUN otherwise: cmdOut<=imemData; pcOut<=pc; cmdValid<=1; pc<=pc+4.
- When the state is WAIT_JR and jrValid is asserted on the same edge as brTaken, brTaken wins and jrTarget is discarded.
- pcOut during bubbles: holds its previous value. Consumers gate all use of it with cmdValid.
- bubbleCount increments on every edge that loads NOP into cmdOut (cases 1, 3, 4). It saturates at 16'hFFFF and does not wrap.
- stall asserted in WAIT_JR has no effect; the block is already emitting bubbles there.
- imemAddr always equals the pc register; no combinational path exists from stall, brTaken or jrValid to imemAddr.
- flush = brTaken, combinational. It is the only combinational output.

Test Plan:
1. Reset mid-run, then release with RESET_PC=0 and imem[0..2] = ADDI words -> cmdOut sequence imem[0], imem[4], imem[8]; pcOut 0, 4, 8; cmdValid=1 each cycle. Asserting reset at any point forces pc=0 and cmdValid=0 immediately, before the next edge.
2. J at PC 0x0000_0010 with imm26=0x000_0040 -> next imemAddr=0x0000_0100. The J word appears on cmdOut with cmdValid=1, and no bubble is inserted (bubbleCount unchanged).
3. JR at PC 0x20, jrValid held low for 2 cycles, then jrTarget=0x400 with jrValid=1 -> cmdOut sequence is JR, NOP, NOP, NOP, then imem[0x400]. cmdValid pattern is 1,0,0,0,1 and bubbleCount=3.
4. brTaken=1 with brTarget=0x80 while stall=1 and state=RUN -> flush=1 in the same cycle. Next edge: imemAddr=0x80, cmdOut=NOP, cmdValid=0, bubbleCount+1.
5. stall held 3 cycles at PC 0x30 -> imemAddr stays 0x30 and cmdOut/pcOut/cmdValid are frozen. On release, cmdOut=imem[0x30] and the PC advances to 0x34.
6. Edge cases:
   - pc=0xFFFF_FFFC with a sequential instruction -> next pc=0x0000_0000.
   - Force bubbleCount to 16'hFFFF via a long WAIT_JR -> it stays 16'hFFFF.
   - WAIT_JR with jrValid and brTaken on the same edge -> pc=brTarget.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers the IF/ID instruction and PC,
// resolves J/JAL in fetch and parks on JR until the register value arrives.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imemData,
    output logic [31:0] imemAddr,
    input  logic        stall,
    input  logic        brTaken,
    input  logic [31:0] brTarget,
    input  logic        jrValid,
    input  logic [31:0] jrTarget,
    output logic [31:0] cmdOut,
    output logic [31:0] pcOut,
    output logic        cmdValid,
    output logic        flush,
    output logic [15:0] bubbleCount
);

    typedef enum logic {
        RUN,
        WAIT_JR
    } fetchState_t;

    fetchState_t state;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] jumpTarget;
    logic [5:0]  opcode;
    logic        isJump;
    logic        isJr;
    logic        loadBubble;

    assign pcPlus4    = pc + 32'd4;
    assign opcode     = imemData[31:26];
    assign isJump     = (opcode == 6'b000010) || (opcode == 6'b000011);
    assign isJr       = (opcode == 6'b000000) && (imemData[5:0] == 6'b001000);
    assign jumpTarget = {pcPlus4[31:28], imemData[25:0], 2'b00};

    // Every edge that pushes NOP into IF/ID: a taken branch or any WAIT_JR cycle.
    assign loadBubble = brTaken || (state == WAIT_JR);

    assign imemAddr = pc;
    assign flush    = brTaken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            cmdOut      <= NOP;
            pcOut       <= 32'h0000_0000;
            cmdValid    <= 1'b0;
            bubbleCount <= 16'h0000;
        end else begin
            if (loadBubble && (bubbleCount != 16'hFFFF)) begin
                bubbleCount <= bubbleCount + 16'd1;
            end

            if (brTaken) begin
                pc       <= brTarget;
                cmdOut   <= NOP;
                cmdValid <= 1'b0;
                state    <= RUN;
            end else if (state == WAIT_JR) begin
                // Stall is deliberately ignored here; bubbles are already flowing.
                if (jrValid) begin
                    pc    <= jrTarget;
                    state <= RUN;
                end
                cmdOut   <= NOP;
                cmdValid <= 1'b0;
            end else if (!stall) begin
                cmdOut   <= imemData;
                pcOut    <= pc;
                cmdValid <= 1'b1;
                if (isJump) begin
                    pc <= jumpTarget;
                end else if (isJr) begin
                    state <= WAIT_JR;
                end else begin
                    pc <= pcPlus4;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a fixed instruction memory, hand-computed
// expected IF/ID contents, PC and bubble counts after each edge.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imemData;
    logic [31:0] imemAddr;
    logic        stall;
    logic        brTaken;
    logic [31:0] brTarget;
    logic        jrValid;
    logic [31:0] jrTarget;
    logic [31:0] cmdOut;
    logic [31:0] pcOut;
    logic        cmdValid;
    logic        flush;
    logic [15:0] bubbleCount;

    int compared;
    int mismatched;

    localparam logic [31:0] J_WORD  = 32'h0800_0040;
    localparam logic [31:0] JR_WORD = 32'h03E0_0008;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP     (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imemData   (imemData),
        .imemAddr   (imemAddr),
        .stall      (stall),
        .brTaken    (brTaken),
        .brTarget   (brTarget),
        .jrValid    (jrValid),
        .jrTarget   (jrTarget),
        .cmdOut     (cmdOut),
        .pcOut      (pcOut),
        .cmdValid   (cmdValid),
        .flush      (flush),
        .bubbleCount(bubbleCount)
    );

    function automatic logic [31:0] addiWord(input logic [31:0] addr);
        return {6'b001000, 5'd1, 5'd2, addr[15:0]};
    endfunction

    // J at 0x10 targets 0x100, JR sits at 0x20, everything else is an ADDI.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0000_0010: return J_WORD;
            32'h0000_0020: return JR_WORD;
            default:       return addiWord(addr);
        endcase
    endfunction

    assign imemData = memWord(imemAddr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic br, input logic [31:0] brT,
                                 input logic jrV, input logic [31:0] jrT,
                                 input logic st);
        brTaken  = br;
        brTarget = brT;
        jrValid  = jrV;
        jrTarget = jrT;
        stall    = st;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] expCmd,
                             input logic [31:0] expPc, input logic expValid,
                             input logic [31:0] expAddr, input logic [15:0] expBubbles);
        checkOutput({tag, ".cmdOut"}, cmdOut, expCmd);
        checkOutput({tag, ".pcOut"}, pcOut, expPc);
        checkOutput({tag, ".cmdValid"}, {31'd0, cmdValid}, {31'd0, expValid});
        checkOutput({tag, ".imemAddr"}, imemAddr, expAddr);
        checkOutput({tag, ".bubbleCount"}, {16'd0, bubbleCount}, {16'd0, expBubbles});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        brTaken    = 1'b0;
        brTarget   = 32'h0;
        jrValid    = 1'b0;
        jrTarget   = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkIfId("reset", 32'h0, 32'h0, 1'b0, 32'h0, 16'h0);
        checkOutput("reset.flush", {31'd0, flush}, 32'h0);

        // Run two instructions, then hit reset between edges.
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("preReset", addiWord(32'h4), 32'h4, 1'b1, 32'h8, 16'h0);
        #2;
        reset = 1'b1;
        #1;
        checkIfId("asyncReset", 32'h0, 32'h0, 1'b0, 32'h0, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sequential fetch from 0, then the J at 0x10 redirects without a bubble.
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("seq0", addiWord(32'h0), 32'h0, 1'b1, 32'h4, 16'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("seq4", addiWord(32'h4), 32'h4, 1'b1, 32'h8, 16'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("seq8", addiWord(32'h8), 32'h8, 1'b1, 32'hC, 16'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("seqC", addiWord(32'hC), 32'hC, 1'b1, 32'h10, 16'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("jump", J_WORD, 32'h10, 1'b1, 32'h100, 16'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("jumpDest", addiWord(32'h100), 32'h100, 1'b1, 32'h104, 16'h0);

        // Taken branch under stall: flush is combinational, branch wins the edge.
        brTaken  = 1'b1;
        brTarget = 32'h80;
        stall    = 1'b1;
        #1;
        checkOutput("brFlush", {31'd0, flush}, 32'h1);
        checkOutput("brNoComboAddr", imemAddr, 32'h104);
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
        checkIfId("brStall", 32'h0, 32'h100, 1'b0, 32'h80, 16'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("flushLow", {31'd0, flush}, 32'h0);
        checkIfId("brDest", addiWord(32'h80), 32'h80, 1'b1, 32'h84, 16'h1);

        // JR at 0x20: three bubbles, stall ignored while waiting.
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        checkIfId("toJr", 32'h0, 32'h80, 1'b0, 32'h20, 16'h2);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("jrIssue", JR_WORD, 32'h20, 1'b1, 32'h20, 16'h2);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("jrWait1", 32'h0, 32'h20, 1'b0, 32'h20, 16'h3);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkIfId("jrWait2", 32'h0, 32'h20, 1'b0, 32'h20, 16'h4);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
        checkIfId("jrResolve", 32'h0, 32'h20, 1'b0, 32'h400, 16'h5);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("jrDest", addiWord(32'h400), 32'h400, 1'b1, 32'h404, 16'h5);

        // Stall for three edges at 0x30 freezes everything, no bubbles counted.
        applyStimulus(1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
        checkIfId("to30", 32'h0, 32'h400, 1'b0, 32'h30, 16'h6);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checkIfId("stallHold", 32'h0, 32'h400, 1'b0, 32'h30, 16'h6);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("stallRelease", addiWord(32'h30), 32'h30, 1'b1, 32'h34, 16'h6);

        // PC wraps from the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        checkIfId("toTop", 32'h0, 32'h30, 1'b0, 32'hFFFF_FFFC, 16'h7);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("wrap", addiWord(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1, 32'h0, 16'h7);

        // Branch and JR target on the same edge: branch wins, state returns to RUN.
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("jrIssue2", JR_WORD, 32'h20, 1'b1, 32'h20, 16'h8);
        applyStimulus(1'b1, 32'h500, 1'b1, 32'h400, 1'b0);
        checkIfId("brBeatsJr", 32'h0, 32'h20, 1'b0, 32'h500, 16'h9);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("brBeatsJrDest", addiWord(32'h500), 32'h500, 1'b1, 32'h504, 16'h9);

        // Long JR wait drives the bubble counter into saturation.
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("jrIssue3", JR_WORD, 32'h20, 1'b1, 32'h20, 16'hA);
        for (int i = 0; i < 65525; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
        checkIfId("satReach", 32'h0, 32'h20, 1'b0, 32'h20, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
        checkIfId("satHold", 32'h0, 32'h20, 1'b0, 32'h20, 16'hFFFF);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
        checkIfId("satResolve", 32'h0, 32'h20, 1'b0, 32'h600, 16'hFFFF);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkIfId("satDest", addiWord(32'h600), 32'h600, 1'b1, 32'h604, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
